// File: rtl/matrix_mopa_wr.sv
// rtl/matrix_mopa_wr.sv - 8-bit outer-product write sequencer for the 4x32 matrix file
// Optional MOPA_SAT_EN: element results saturate at 8'hFF instead of wrapping mod 256.
module matrix_mopa_wr #(
  parameter int ELEM_W = 8,
  parameter int ROWS   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         acc_mode,
  input  logic [31:0]  vec_a,
  input  logic [31:0]  vec_b,
  input  logic [127:0] m_in,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         ctrl_stall,
  output logic         w_matrix_en,
  output logic [1:0]   w_matrix_index,
  output logic [31:0]  w_matrix_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   row;
  logic [31:0]  a_q;
  logic [31:0]  b_q;
  logic [127:0] m_q;
  logic         acc_q;
  logic [1:0]   row_next;
  logic [31:0]  next_row_data;

  // One matrix row: each byte is (base + a * b_j) reduced to 8 bits.
  function automatic logic [31:0] row_calc(input logic [7:0]  a,
                                           input logic [31:0] b,
                                           input logic [31:0] m,
                                           input logic        acc);
    logic [31:0] r;
    logic [7:0]  base;
`ifdef MOPA_SAT_EN
    logic [15:0] prod;
    logic [16:0] sum;
`else
    logic [7:0]  prod;
`endif
    r = '0;
    for (int j = 0; j < 4; j++) begin
      base = acc ? m[8*j +: 8] : 8'd0;
`ifdef MOPA_SAT_EN
      prod = 16'(a) * 16'(b[8*j +: 8]);
      sum  = {1'b0, prod} + {9'd0, base};
      r[8*j +: 8] = (sum > 17'd255) ? 8'hFF : sum[7:0];
`else
      prod = a * b[8*j +: 8];
      r[8*j +: 8] = base + prod;
`endif
    end
    return r;
  endfunction

  assign row_next      = row + 2'd1;
  assign next_row_data = row_calc(a_q[{row_next, 3'b000} +: 8], b_q,
                                  m_q[{row_next, 5'b00000} +: 32], acc_q);

  // The issuing instruction must be held in the very cycle it raises start.
  assign ctrl_stall = busy | (start & (state == IDLE));

  // Sequencer: writes are registered one cycle ahead so row r appears in cycle r+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      row            <= 2'd0;
      a_q            <= '0;
      b_q            <= '0;
      m_q            <= '0;
      acc_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      w_matrix_en    <= 1'b0;
      w_matrix_index <= 2'd0;
      w_matrix_data  <= '0;
    end else begin
      done           <= 1'b0;
      w_matrix_en    <= 1'b0;
      w_matrix_index <= 2'd0;
      w_matrix_data  <= '0;
      case (state)
        IDLE: begin
          // flush has priority over a simultaneous start
          if (start && !flush) begin
            a_q            <= vec_a;
            b_q            <= vec_b;
            m_q            <= m_in;
            acc_q          <= acc_mode;
            row            <= 2'd0;
            state          <= RUN;
            busy           <= 1'b1;
            w_matrix_en    <= 1'b1;
            w_matrix_data  <= row_calc(vec_a[7:0], vec_b, m_in[31:0], acc_mode);
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            row   <= 2'd0;
            busy  <= 1'b0;
          end else if (row == 2'd3) begin
            state <= DONE;
            row   <= 2'd0;
            done  <= 1'b1;
          end else begin
            row            <= row_next;
            w_matrix_en    <= 1'b1;
            w_matrix_index <= row_next;
            w_matrix_data  <= next_row_data;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
